// File: rtl/poly_horner_eval_if.sv
// Handshake and coefficient bus for poly_horner_eval.
// master: sequencer drives start/x/coef; slave: evaluator returns status/result.
interface poly_horner_eval_if #(
  parameter int W   = 16,
  parameter int DEG = 2,
  parameter int AW  = $clog2(DEG + 1)
);
  logic          inicio;
  logic [W-1:0]  x;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_data;
  logic          ocupado;
  logic          pronto;
  logic [W-1:0]  resultado;
  logic          overflow;

  modport master (
    output inicio, x, coef_we, coef_addr, coef_data,
    input  ocupado, pronto, resultado, overflow
  );

  modport slave (
    input  inicio, x, coef_we, coef_addr, coef_data,
    output ocupado, pronto, resultado, overflow
  );
endinterface

// File: rtl/poly_horner_eval.sv
// Horner evaluator: one multiply-add per clock, coefficient bank, sticky overflow.
// Ports: clk, rst (async active-low), bus (poly_horner_eval_if.slave).
module poly_horner_eval #(
  parameter  int W   = 16,
  parameter  int DEG = 2,
  localparam int AW  = $clog2(DEG + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  poly_horner_eval_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  xr_q, xr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  coef_q [0:DEG];
  logic [W-1:0]  coef_d [0:DEG];

  logic [AW-1:0] idx;
  logic [W-1:0]  cur_coef;
  logic [2*W:0]  mac;
  logic          addr_ok;

  assign idx      = cnt_q - AW'(1);
  assign cur_coef = coef_q[idx];
  // Full-width MAC; bits above W flag overflow.
  assign mac = {{(W+1){1'b0}}, acc_q}
             * {{(W+1){1'b0}}, xr_q}
             + {{(W+1){1'b0}}, cur_coef};
  assign addr_ok = int'(bus.coef_addr) <= DEG;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    xr_d    = xr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    coef_d  = coef_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.inicio) begin
          xr_d    = bus.x;
          acc_d   = coef_q[DEG];
          cnt_d   = AW'(DEG);
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_STEP;
        end else if (bus.coef_we && addr_ok) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end
      end
      (state_q == S_STEP): begin
        acc_d = mac[W-1:0];
        if (|mac[2*W:W]) ovf_d = 1'b1;
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = S_DONE;
      end
      (state_q == S_DONE): begin
        res_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      xr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      for (int i = 0; i <= DEG; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      for (int i = 0; i <= DEG; i++) coef_q[i] <= coef_d[i];
    end
  end

  assign bus.ocupado   = busy_q;
  assign bus.pronto    = done_q;
  assign bus.resultado = res_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Scoreboard bench for poly_horner_eval: W16/DEG2 and W8/DEG4 instances.
// Stimulus pushes expectations; per-instance monitors pop on pronto.
module tb_poly_horner_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  poly_horner_eval_if #(.W(16), .DEG(2)) ba ();
  poly_horner_eval_if #(.W(8),  .DEG(4)) bb ();

  poly_horner_eval #(.W(16), .DEG(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ba)
  );
  poly_horner_eval #(.W(8), .DEG(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bb)
  );

  typedef struct {
    longint res;
    longint ovf;
    int     start;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor A
  int busy_a = 0;
  bit prev_a = 0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_a) begin
      busy_a = 0;
      prev_a = 0;
    end else begin
      if (ba.ocupado) busy_a++;
      if (ba.pronto) begin
        chk("a_pulse_width", longint'(prev_a), 0);
        if (qa.size() == 0) begin
          chk("a_unexpected_pronto", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_resultado", longint'(ba.resultado), e.res);
          chk("a_overflow", longint'(ba.overflow), e.ovf);
          chk("a_latency", longint'(cyc - e.start), 3);
          chk("a_busy_cycles", longint'(busy_a), 3);
        end
        busy_a = 0;
      end
      prev_a = ba.pronto;
    end
  end

  // Monitor B
  int busy_b = 0;
  bit prev_b = 0;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_b) begin
      busy_b = 0;
      prev_b = 0;
    end else begin
      if (bb.ocupado) busy_b++;
      if (bb.pronto) begin
        chk("b_pulse_width", longint'(prev_b), 0);
        if (qb.size() == 0) begin
          chk("b_unexpected_pronto", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_resultado", longint'(bb.resultado), e.res);
          chk("b_overflow", longint'(bb.overflow), e.ovf);
          chk("b_latency", longint'(cyc - e.start), 5);
          chk("b_busy_cycles", longint'(busy_b), 5);
        end
        busy_b = 0;
      end
      prev_b = bb.pronto;
    end
  end

  task automatic wr_a(int addr, int data);
    @(negedge clk);
    ba.coef_we   = 1'b1;
    ba.coef_addr = addr[1:0];
    ba.coef_data = data[15:0];
    @(negedge clk);
    ba.coef_we   = 1'b0;
  endtask

  task automatic go_a(int xv, longint res, longint ovf, bit push);
    exp_t e;
    @(negedge clk);
    ba.inicio = 1'b1;
    ba.x      = xv[15:0];
    e.res = res;
    e.ovf = ovf;
    e.start = cyc + 1;
    if (push) qa.push_back(e);
    @(negedge clk);
    ba.inicio = 1'b0;
  endtask

  task automatic wait_a();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ba.ocupado && !ba.pronto && qa.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("a_timeout", 0, 1);
  endtask

  task automatic wr_b(int addr, int data);
    @(negedge clk);
    bb.coef_we   = 1'b1;
    bb.coef_addr = addr[2:0];
    bb.coef_data = data[7:0];
    @(negedge clk);
    bb.coef_we   = 1'b0;
  endtask

  task automatic go_b(int xv, longint res, longint ovf);
    exp_t e;
    @(negedge clk);
    bb.inicio = 1'b1;
    bb.x      = xv[7:0];
    e.res = res;
    e.ovf = ovf;
    e.start = cyc + 1;
    qb.push_back(e);
    @(negedge clk);
    bb.inicio = 1'b0;
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bb.ocupado && !bb.pronto && qb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("b_timeout", 0, 1);
  endtask

  initial begin : stim
    exp_t e;
    bit seen;
    ba.inicio = 0; ba.x = '0; ba.coef_we = 0;
    ba.coef_addr = '0; ba.coef_data = '0;
    bb.inicio = 0; bb.x = '0; bb.coef_we = 0;
    bb.coef_addr = '0; bb.coef_data = '0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_ocupado", longint'(ba.ocupado), 0);
    chk("rst_a_pronto", longint'(ba.pronto), 0);
    chk("rst_a_resultado", longint'(ba.resultado), 0);
    chk("rst_a_overflow", longint'(ba.overflow), 0);
    chk("rst_b_ocupado", longint'(bb.ocupado), 0);
    chk("rst_b_resultado", longint'(bb.resultado), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // x^2 + 2x + 2 at x=2; out-of-range address must be dropped
    wr_a(2, 1);
    wr_a(1, 2);
    wr_a(0, 2);
    wr_a(3, 55);
    go_a(2, 10, 0, 1);
    // busy: coefficient write, restart and x change all ignored
    ba.coef_we   = 1'b1;
    ba.coef_addr = 2'd0;
    ba.coef_data = 16'd99;
    ba.inicio    = 1'b1;
    ba.x         = 16'd5;
    @(negedge clk);
    ba.coef_we = 1'b0;
    ba.inicio  = 1'b0;
    wait_a();
    chk("a_held_after_busy", longint'(ba.resultado), 10);
    go_a(2, 10, 0, 1);
    wait_a();

    // back-to-back start on the pronto cycle
    go_a(2, 10, 0, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ba.pronto) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("a_b2b_timeout", 0, 1);
    ba.inicio = 1'b1;
    ba.x      = 16'd1;
    e.res = 5;
    e.ovf = 0;
    e.start = cyc + 1;
    qa.push_back(e);
    @(negedge clk);
    ba.inicio = 1'b0;
    chk("a_b2b_busy", longint'(ba.ocupado), 1);
    chk("a_b2b_hold1", longint'(ba.resultado), 10);
    @(negedge clk);
    chk("a_b2b_hold2", longint'(ba.resultado), 10);
    wait_a();

    // wrap-around with sticky overflow, then cleared on next start
    wr_a(1, 0);
    wr_a(0, 0);
    go_a(300, 24464, 1, 1);
    wait_a();
    go_a(3, 9, 0, 1);
    wait_a();

    // async reset mid-STEP
    go_a(7, 0, 0, 0);
    chk("a_busy_pre_rst", longint'(ba.ocupado), 1);
    #2 rst_a = 1'b0;
    #1;
    chk("a_rst_ocupado", longint'(ba.ocupado), 0);
    chk("a_rst_pronto", longint'(ba.pronto), 0);
    chk("a_rst_resultado", longint'(ba.resultado), 0);
    chk("a_rst_overflow", longint'(ba.overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    go_a(7, 0, 0, 1);
    wait_a();

    // DEG=4, W=8: x^4 + 1
    wr_b(4, 1);
    wr_b(0, 1);
    go_b(3, 82, 0);
    wait_b();
    go_b(4, 1, 1);
    wait_b();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
- Parametrised successor to the fixed quadratic control/datapath pair.
- Evaluates an unsigned polynomial P(x) = a[DEG]*x^DEG + ... + a[1]*x + a[0] of configurable degree and width using Horner's method, one multiply-add step per clock.
- Adds the following, which the quadratic block lacks:
  - a writable coefficient register bank;
  - a start/busy/done handshake;
  - a sticky overflow flag.
- Sits inside the arithmetic subsystem, driven by a sequencer that loads coefficients and then pulses inicio.

Parameters:
W, 16, data width of x, coefficients and resultado (W >= 4)
DEG, 2, polynomial degree (DEG >= 1)
AW, $clog2(DEG+1), coefficient address width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
inicio  input  1  start request, sampled on rising clk
x  input  W  evaluation point, latched when start is accepted
coef_we  input  1  coefficient write enable
coef_addr  input  AW  coefficient index (0..DEG)
coef_data  input  W  coefficient write value
ocupado  output  1  high while a computation is in progress
pronto  output  1  one-cycle done pulse
resultado  output  W  result of last completed evaluation, held
overflow  output  1  high if any Horner step of the last evaluation exceeded W bits

Behaviour:
- Reset: rst low asynchronously forces the following, regardless of state (including mid-computation):
  - state IDLE;
  - ocupado=0, pronto=0, resultado=0, overflow=0;
  - all coefficients a[0..DEG]=0, internal acc, xr and count cleared.
- FSM states:
  - IDLE:
    - On an edge with inicio=1: xr<=x, acc<=a[DEG], count<=DEG, overflow<=0, ocupado<=1, go to STEP.
    - Otherwise remain in IDLE.
  - STEP:
    - Each edge: acc <= (acc*xr + a[count-1]) mod 2^W, count<=count-1.
    - When count==1 on that edge, go to DONE.
    - Exactly DEG STEP edges per evaluation.
  - DONE:
    - Next edge: resultado<=acc, pronto<=1, ocupado<=0, go to IDLE.
- Latency:
  - Start accepted at edge 0.
  - STEP edges 1..DEG.
  - resultado and pronto update at edge DEG+1.
  - pronto is high for exactly one cycle, then 0.
  - With DEG=2, pronto is high 3 cycles after the accepted start.
- Back-to-back: inicio=1 on the same edge pronto goes high (state IDLE) starts a new run; resultado stays held until that run's DONE.
- inicio while ocupado=1: ignored, no queueing.
- Coefficient writes:
  - Performed only in IDLE and only when inicio=0 on that edge.
  - A write with coef_addr > DEG is dropped.
  - Writes while ocupado=1, or on the start edge, are ignored; the running evaluation always sees a stable coefficient set.
- Arithmetic:
  - Unsigned.
  - Each step computes the full 2W+1-bit value acc*xr + a[i].
  - acc keeps the low W bits (wrap-around).
  - If any of bits [2W:W] is nonzero in any step, overflow is set sticky for this run.
  - overflow is cleared at the next accepted start.
  - overflow is valid when pronto=1 and held with resultado.
- x changes after the start edge have no effect (xr latched).
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. W=16, DEG=2; write a2=1, a1=2, a0=2; x=2; pulse inicio -> pronto exactly one cycle, 3 cycles after the start edge; resultado=10, overflow=0; ocupado high for 3 cycles.
2. a2=1, a1=0, a0=0; x=300 -> resultado=24464 (90000 mod 65536), overflow=1. Rerun with x=3 -> resultado=9, overflow=0 (sticky flag cleared on start).
3. During busy, drive coef_we with addr 0, data 99, and inicio=1 -> both ignored. Result of scenario 1 unchanged (10); a following run still gives 10; only one pronto.
4. Assert inicio on the same edge pronto is high, with x=1 -> second run starts immediately; resultado=5 at its pronto; resultado holds 10 in between.
5. Pull rst low mid-STEP (between clock edges) -> ocupado, pronto, resultado and overflow go to 0 immediately. After release, inicio with x=7 gives resultado=0 (coefficients cleared).
6. DEG=4, W=8 instance; coefficients a4..a0 = 1,0,0,0,1; x=3 -> resultado=82, pronto 5 cycles after start, overflow=0. x=4 -> 257 mod 256 = 1, overflow=1.
